// File: rtl/via_pkg.sv
// Shared constants for the mac_via peripheral: register offsets, IFR bit
// indices, PCR/ACR control bit positions and the port read-back helper.
package via_pkg;

   localparam logic [3:0] RS_ORB    = 4'h0;
   localparam logic [3:0] RS_ORA    = 4'h1;
   localparam logic [3:0] RS_DDRB   = 4'h2;
   localparam logic [3:0] RS_DDRA   = 4'h3;
   localparam logic [3:0] RS_T1CL   = 4'h4;
   localparam logic [3:0] RS_T1CH   = 4'h5;
   localparam logic [3:0] RS_T1LL   = 4'h6;
   localparam logic [3:0] RS_T1LH   = 4'h7;
   localparam logic [3:0] RS_T2CL   = 4'h8;
   localparam logic [3:0] RS_T2CH   = 4'h9;
   localparam logic [3:0] RS_SR     = 4'hA;
   localparam logic [3:0] RS_ACR    = 4'hB;
   localparam logic [3:0] RS_PCR    = 4'hC;
   localparam logic [3:0] RS_IFR    = 4'hD;
   localparam logic [3:0] RS_IER    = 4'hE;
   localparam logic [3:0] RS_ORA_NH = 4'hF;

   localparam int IFR_CA2 = 0;
   localparam int IFR_CA1 = 1;
   localparam int IFR_SR  = 2;
   localparam int IFR_CB2 = 3;
   localparam int IFR_CB1 = 4;
   localparam int IFR_T2  = 5;
   localparam int IFR_T1  = 6;
   localparam int IFR_IRQ = 7;

   localparam int PCR_CA1    = 0;
   localparam int PCR_CA2    = 2;
   localparam int PCR_CB1    = 4;
   localparam int PCR_CB2    = 6;
   localparam int ACR_T1FREE = 6;

   // Output bits read back from the register, input bits from the pins.
   function automatic logic [7:0] port_read(input logic [7:0] or_q,
                                            input logic [7:0] ddr,
                                            input logic [7:0] pin);
      return (or_q & ddr) | (pin & ~ddr);
   endfunction

endpackage

// File: rtl/via_timer.sv
// One VIA interval timer: latch, down-counter and arm flag. expire pulses on
// the tick that finds the counter at zero while armed or free-running.
module via_timer #(
   parameter int TIMER_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tick,
   input  logic        free_run,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic        load,
   input  logic [7:0]  din,
   output logic [15:0] cnt,
   output logic [15:0] latch,
   output logic        expire
);

   logic [TIMER_W-1:0] r_cnt;
   logic [TIMER_W-1:0] r_latch;
   logic               r_armed;
   logic               w_zero;

   assign w_zero = (r_cnt == '0);
   assign expire = tick & ~load & w_zero & (r_armed | free_run);
   assign cnt    = 16'(r_cnt);
   assign latch  = 16'(r_latch);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '1;
         r_latch <= '1;
         r_armed <= 1'b0;
      end else begin
         if (wr_lo) r_latch[7:0] <= din;
         if (wr_hi || load) r_latch[TIMER_W-1:8] <= din[TIMER_W-9:0];
         // A load takes priority over a coincident tick.
         if (load) begin
            r_cnt   <= {din[TIMER_W-9:0], r_latch[7:0]};
            r_armed <= 1'b1;
         end else if (tick) begin
            if (w_zero) begin
               if (free_run) begin
                  r_cnt <= r_latch;
               end else begin
                  r_cnt   <= '1;
                  r_armed <= 1'b0;
               end
            end else begin
               r_cnt <= r_cnt - TIMER_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/mac_via.sv
// VIA-style peripheral: two 8-bit ports, four edge-interrupt inputs, two
// interval timers and the IFR/IER interrupt logic behind a 16-register map.
module mac_via
   import via_pkg::*;
#(
   parameter int         TIMER_W     = 16,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] PA_RESET    = 8'h00
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       cs,
   input  logic       en,
   input  logic       rw,
   input  logic [3:0] rs,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic [7:0] pa_in,
   input  logic [7:0] pb_in,
   output logic [7:0] pa_out,
   output logic [7:0] pb_out,
   output logic [7:0] pa_oe,
   output logic [7:0] pb_oe,
   input  logic       ca1,
   input  logic       ca2,
   input  logic       cb1,
   input  logic       cb2,
   output logic       irq_n
);

   logic [7:0]  r_ora, r_orb, r_ddra, r_ddrb, r_sr, r_acr, r_pcr, r_dout;
   logic [6:0]  r_ifr, r_ier;
   logic        r_irq_n;
   logic [19:0] r_sync [SYNC_STAGES];
   logic [3:0]  r_ctl_prev;

   logic        w_acc, w_rd, w_wr, w_ifr7;
   logic [19:0] w_raw, w_s;
   logic [7:0]  w_pa_s, w_pb_s, w_rdata;
   logic [6:0]  w_set, w_clr;
   logic [15:0] w_t1_cnt, w_t1_latch, w_t2_cnt, w_t2_latch_unused;
   logic        w_t1_exp, w_t2_exp;

   function automatic logic edge_hit(input logic rising, input logic cur, input logic prev);
      return rising ? (cur & ~prev) : (~cur & prev);
   endfunction

   assign w_acc  = cs & en;
   assign w_rd   = w_acc & rw;
   assign w_wr   = w_acc & ~rw;
   assign w_raw  = {pb_in, pa_in, cb2, cb1, ca2, ca1};
   assign w_s    = r_sync[SYNC_STAGES-1];
   assign w_pa_s = w_s[11:4];
   assign w_pb_s = w_s[19:12];
   assign w_ifr7 = |(r_ifr & r_ier);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
         r_ctl_prev <= '0;
      end else begin
         r_sync[0] <= w_raw;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_ctl_prev <= w_s[3:0];
      end
   end

   via_timer #(.TIMER_W(TIMER_W)) u_t1 (
      .clk(clk), .reset_n(reset_n), .tick(tick), .free_run(r_acr[ACR_T1FREE]),
      .wr_lo(w_wr && (rs == RS_T1CL || rs == RS_T1LL)),
      .wr_hi(w_wr && rs == RS_T1LH), .load(w_wr && rs == RS_T1CH),
      .din(din), .cnt(w_t1_cnt), .latch(w_t1_latch), .expire(w_t1_exp)
   );

   via_timer #(.TIMER_W(TIMER_W)) u_t2 (
      .clk(clk), .reset_n(reset_n), .tick(tick), .free_run(1'b0),
      .wr_lo(w_wr && rs == RS_T2CL), .wr_hi(1'b0), .load(w_wr && rs == RS_T2CH),
      .din(din), .cnt(w_t2_cnt), .latch(w_t2_latch_unused), .expire(w_t2_exp)
   );

   always_comb begin
      w_set          = '0;
      w_set[IFR_CA2] = edge_hit(r_pcr[PCR_CA2], w_s[1], r_ctl_prev[1]);
      w_set[IFR_CA1] = edge_hit(r_pcr[PCR_CA1], w_s[0], r_ctl_prev[0]);
      w_set[IFR_CB2] = edge_hit(r_pcr[PCR_CB2], w_s[3], r_ctl_prev[3]);
      w_set[IFR_CB1] = edge_hit(r_pcr[PCR_CB1], w_s[2], r_ctl_prev[2]);
      w_set[IFR_T2]  = w_t2_exp;
      w_set[IFR_T1]  = w_t1_exp;

      w_clr = '0;
      if (w_acc && rs == RS_ORA) w_clr[IFR_CA1:IFR_CA2] = 2'b11;
      if (w_acc && rs == RS_ORB) w_clr[IFR_CB1:IFR_CB2] = 2'b11;
      if (w_wr && rs == RS_IFR) w_clr = w_clr | din[6:0];
      if ((w_wr && rs == RS_T1CH) || (w_rd && rs == RS_T1CL)) w_clr[IFR_T1] = 1'b1;
      if ((w_wr && rs == RS_T2CH) || (w_rd && rs == RS_T2CL)) w_clr[IFR_T2] = 1'b1;
   end

   always_comb begin
      w_rdata = 8'h00;
      case (rs)
         RS_ORB:             w_rdata = port_read(r_orb, r_ddrb, w_pb_s);
         RS_ORA, RS_ORA_NH:  w_rdata = port_read(r_ora, r_ddra, w_pa_s);
         RS_DDRB:            w_rdata = r_ddrb;
         RS_DDRA:            w_rdata = r_ddra;
         RS_T1CL:            w_rdata = w_t1_cnt[7:0];
         RS_T1CH:            w_rdata = w_t1_cnt[15:8];
         RS_T1LL:            w_rdata = w_t1_latch[7:0];
         RS_T1LH:            w_rdata = w_t1_latch[15:8];
         RS_T2CL:            w_rdata = w_t2_cnt[7:0];
         RS_T2CH:            w_rdata = w_t2_cnt[15:8];
         RS_SR:              w_rdata = r_sr;
         RS_ACR:             w_rdata = r_acr;
         RS_PCR:             w_rdata = r_pcr;
         RS_IFR:             w_rdata = {w_ifr7, r_ifr};
         RS_IER:             w_rdata = {1'b1, r_ier};
         default:            w_rdata = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ora   <= PA_RESET;
         r_orb   <= '0;
         r_ddra  <= '0;
         r_ddrb  <= '0;
         r_sr    <= '0;
         r_acr   <= '0;
         r_pcr   <= '0;
         r_ifr   <= '0;
         r_ier   <= '0;
         r_dout  <= '0;
         r_irq_n <= 1'b1;
      end else begin
         if (w_wr) begin
            case (rs)
               RS_ORB:            r_orb  <= din;
               RS_ORA, RS_ORA_NH: r_ora  <= din;
               RS_DDRB:           r_ddrb <= din;
               RS_DDRA:           r_ddra <= din;
               RS_SR:             r_sr   <= din;
               RS_ACR:            r_acr  <= din;
               RS_PCR:            r_pcr  <= din;
               RS_IER:            r_ier  <= din[7] ? (r_ier | din[6:0]) : (r_ier & ~din[6:0]);
               default:           ;
            endcase
         end
         if (w_rd) r_dout <= w_rdata;
         // Set beats clear; the SR flag has no source and stays 0.
         r_ifr   <= ((r_ifr & ~w_clr) | w_set) & ~(7'd1 << IFR_SR);
         r_irq_n <= ~w_ifr7;
      end
   end

   assign dout   = r_dout;
   assign irq_n  = r_irq_n;
   assign pa_out = r_ora;
   assign pb_out = r_orb;
   assign pa_oe  = r_ddra;
   assign pb_oe  = r_ddrb;

endmodule

// File: tb/tb_mac_via.sv
// Self-checking bench for mac_via: register table plus timer, edge and reset sequences.
module tb_mac_via;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0, cs = 1'b0, en = 1'b0, rw = 1'b0;
   logic [3:0] rs = '0;
   logic [7:0] din = '0, dout;
   logic [7:0] pa_in = 8'h55, pb_in = 8'h3C;
   logic [7:0] pa_out, pb_out, pa_oe, pb_oe;
   logic       ca1 = 1'b0, ca2 = 1'b0, cb1 = 1'b0, cb2 = 1'b0;
   logic       irq_n;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] q_exp[$];
   string      q_name[$];

   typedef struct {
      logic       rd;
      logic [3:0] rs;
      logic [7:0] wdata;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   mac_via #(.TIMER_W(16), .SYNC_STAGES(S), .PA_RESET(8'h00)) dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .cs(cs), .en(en), .rw(rw),
      .rs(rs), .din(din), .dout(dout), .pa_in(pa_in), .pb_in(pb_in),
      .pa_out(pa_out), .pb_out(pb_out), .pa_oe(pa_oe), .pb_oe(pb_oe),
      .ca1(ca1), .ca2(ca2), .cb1(cb1), .cb2(cb2), .irq_n(irq_n)
   );

   task automatic check8(input string nm, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; en = 1'b1; rw = 1'b0; rs = a; din = d;
      @(negedge clk);
      cs = 1'b0; en = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input string nm);
      q_exp.push_back(exp);
      q_name.push_back(nm);
      @(negedge clk);
      cs = 1'b1; en = 1'b1; rw = 1'b1; rs = a;
      @(negedge clk);
      cs = 1'b0; en = 1'b0; rw = 1'b0;
      check8(q_name.pop_front(), dout, q_exp.pop_front());
   endtask

   task automatic pulse_tick();
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      ca1 = 1'b0; cb1 = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      // {rd, rs, wdata, expected read value}
      tbl.push_back('{1'b1, 4'hE, 8'h00, 8'h80});
      tbl.push_back('{1'b1, 4'hD, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 4'hB, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 4'hC, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 4'h4, 8'h00, 8'hFF});
      tbl.push_back('{1'b1, 4'h5, 8'h00, 8'hFF});
      tbl.push_back('{1'b1, 4'h6, 8'h00, 8'hFF});
      tbl.push_back('{1'b1, 4'h7, 8'h00, 8'hFF});
      tbl.push_back('{1'b1, 4'h8, 8'h00, 8'hFF});
      tbl.push_back('{1'b1, 4'h9, 8'h00, 8'hFF});
      tbl.push_back('{1'b1, 4'h0, 8'h00, 8'h3C});
      tbl.push_back('{1'b1, 4'h1, 8'h00, 8'h55});
      tbl.push_back('{1'b0, 4'hA, 8'h5A, 8'h00});
      tbl.push_back('{1'b1, 4'hA, 8'h00, 8'h5A});
      tbl.push_back('{1'b0, 4'hC, 8'h55, 8'h00});
      tbl.push_back('{1'b1, 4'hC, 8'h00, 8'h55});
      tbl.push_back('{1'b0, 4'hB, 8'h3C, 8'h00});
      tbl.push_back('{1'b1, 4'hB, 8'h00, 8'h3C});
      tbl.push_back('{1'b0, 4'hB, 8'h00, 8'h00});
      tbl.push_back('{1'b0, 4'h2, 8'hF0, 8'h00});
      tbl.push_back('{1'b0, 4'h0, 8'hA5, 8'h00});
      tbl.push_back('{1'b1, 4'h0, 8'h00, 8'hAC});
      tbl.push_back('{1'b1, 4'h2, 8'h00, 8'hF0});
      tbl.push_back('{1'b0, 4'h3, 8'h0F, 8'h00});
      tbl.push_back('{1'b0, 4'h1, 8'hAA, 8'h00});
      tbl.push_back('{1'b1, 4'h1, 8'h00, 8'h5A});
      tbl.push_back('{1'b1, 4'hF, 8'h00, 8'h5A});
      tbl.push_back('{1'b1, 4'h3, 8'h00, 8'h0F});
      tbl.push_back('{1'b0, 4'h6, 8'h34, 8'h00});
      tbl.push_back('{1'b0, 4'h7, 8'h12, 8'h00});
      tbl.push_back('{1'b1, 4'h6, 8'h00, 8'h34});
      tbl.push_back('{1'b1, 4'h7, 8'h00, 8'h12});
      tbl.push_back('{1'b1, 4'h5, 8'h00, 8'hFF});
      tbl.push_back('{1'b0, 4'hE, 8'h83, 8'h00});
      tbl.push_back('{1'b1, 4'hE, 8'h00, 8'h83});
      tbl.push_back('{1'b0, 4'hE, 8'h01, 8'h00});
      tbl.push_back('{1'b1, 4'hE, 8'h00, 8'h82});
      tbl.push_back('{1'b0, 4'hE, 8'h02, 8'h00});
      tbl.push_back('{1'b1, 4'hE, 8'h00, 8'h80});

      repeat (3) @(negedge clk);
      check8("rst_dout", dout, 8'h00);
      check8("rst_irq_n", {7'd0, irq_n}, 8'h01);
      check8("rst_pa_out", pa_out, 8'h00);
      check8("rst_pa_oe", pa_oe, 8'h00);
      reset_n = 1'b1;
      repeat (S + 2) @(negedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rd) do_read(tbl[i].rs, tbl[i].exp, $sformatf("tbl%0d_rs%h", i, tbl[i].rs));
         else           do_write(tbl[i].rs, tbl[i].wdata);
      end
      check8("pa_oe", pa_oe, 8'h0F);
      check8("pa_out", pa_out, 8'hAA);
      check8("pb_oe", pb_oe, 8'hF0);
      check8("pb_out", pb_out, 8'hA5);

      // T1 one-shot: latch 3, expires on the 4th tick.
      do_reset();
      do_write(4'hE, 8'hC0);
      do_write(4'h6, 8'h03);
      do_write(4'h5, 8'h00);
      repeat (3) pulse_tick();
      do_read(4'hD, 8'h00, "t1_no_flag_early");
      pulse_tick();
      check8("t1_irq_lag", {7'd0, irq_n}, 8'h01);
      @(negedge clk);
      check8("t1_irq_low", {7'd0, irq_n}, 8'h00);
      do_read(4'hD, 8'hC0, "t1_ifr_set");
      do_read(4'h4, 8'hFF, "t1_wrap_lo");
      @(negedge clk);
      check8("t1_irq_cleared", {7'd0, irq_n}, 8'h01);

      // T1 free-run: latch 2, fires every third tick and reloads.
      do_reset();
      do_write(4'hE, 8'hC0);
      do_write(4'hB, 8'h40);
      do_write(4'h4, 8'h02);
      do_write(4'h5, 8'h00);
      for (int t = 1; t <= 9; t++) begin
         pulse_tick();
         do_read(4'hD, (t % 3 == 0) ? 8'hC0 : 8'h00, $sformatf("t1fr_ifr_t%0d", t));
         do_read(4'h4, (t % 3 == 0) ? 8'h02 : 8'(2 - t % 3), $sformatf("t1fr_cnt_t%0d", t));
      end

      // T2 one-shot from 1: 1->0, flag and wrap at tick 2, then 8 decrements.
      do_reset();
      do_write(4'hE, 8'hA0);
      do_write(4'h8, 8'h01);
      do_write(4'h9, 8'h00);
      for (int t = 1; t <= 10; t++) begin
         pulse_tick();
         do_read(4'hD, (t == 2) ? 8'hA0 : 8'h00, $sformatf("t2_ifr_t%0d", t));
         if (t == 2) do_write(4'hD, 8'h20);
      end
      do_read(4'h8, 8'hF7, "t2_cnt_lo");
      do_read(4'h9, 8'hFF, "t2_cnt_hi");

      // CA1 rising-edge interrupt and flag-clear rules.
      do_reset();
      ca1 = 1'b1;
      repeat (S + 3) @(negedge clk);
      do_write(4'hC, 8'h01);
      do_write(4'hE, 8'h82);
      @(negedge clk);
      ca1 = 1'b0;
      repeat (S + 3) @(negedge clk);
      do_read(4'hD, 8'h00, "ca1_fall_ignored");
      @(negedge clk);
      ca1 = 1'b1;
      repeat (S + 1) @(negedge clk);
      check8("ca1_irq_not_yet", {7'd0, irq_n}, 8'h01);
      @(negedge clk);
      check8("ca1_irq_low", {7'd0, irq_n}, 8'h00);
      do_read(4'hF, 8'h55, "ora_nh_read");
      do_read(4'hD, 8'h82, "ca1_kept_by_rsF");
      do_read(4'h1, 8'h55, "ora_read");
      do_read(4'hD, 8'h00, "ca1_cleared_by_ora");

      // Edge landing on the same clock as an IFR clear write: set wins.
      ca1 = 1'b0;
      repeat (S + 3) @(negedge clk);
      @(negedge clk);
      ca1 = 1'b1;
      repeat (S - 1) @(negedge clk);
      do_write(4'hD, 8'h02);
      do_read(4'hD, 8'h82, "set_beats_clear");
      do_write(4'hD, 8'h02);
      do_read(4'hD, 8'h00, "ifr_write_clear");

      // CB1 default falling edge, cleared by an ORB access.
      do_write(4'hE, 8'h90);
      cb1 = 1'b1;
      repeat (S + 3) @(negedge clk);
      cb1 = 1'b0;
      repeat (S + 3) @(negedge clk);
      do_read(4'hD, 8'h90, "cb1_fall_set");
      do_read(4'h0, 8'h3C, "orb_pins");
      do_read(4'hD, 8'h00, "cb1_cleared_by_orb");

      // Reset mid-count aborts T1 and leaves no flag behind.
      do_reset();
      do_write(4'hE, 8'hC0);
      do_write(4'h1, 8'hAA);
      do_write(4'h3, 8'hFF);
      do_write(4'h6, 8'h05);
      do_write(4'h5, 8'h00);
      repeat (2) pulse_tick();
      do_read(4'hE, 8'hC0, "pre_reset_ier");
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check8("midrst_pa_out", pa_out, 8'h00);
      check8("midrst_pa_oe", pa_oe, 8'h00);
      check8("midrst_dout", dout, 8'h00);
      check8("midrst_irq_n", {7'd0, irq_n}, 8'h01);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) pulse_tick();
      do_read(4'hD, 8'h00, "no_t1_after_reset");
      do_read(4'h5, 8'hFF, "t1_hi_after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
